// File: rtl/register_bank_param.sv
`default_nettype none
// ============================================================================
// Module      : register_bank_param
// Description : Parametrised 2-read / 1-write register bank with optional
//               hardwired-zero register 0, same-cycle write-to-read bypass
//               and a sequential bulk-clear engine (busy/done handshake).
// Revision    : 1.0 - initial release
// ============================================================================
module register_bank_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we3,
    input  logic [AW-1:0]    wa3,
    input  logic [WIDTH-1:0] wd3,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    input  logic             clr_start,
    output logic             clr_busy,
    output logic             clr_done,
    output logic             wr_err
);

    // Depth extended by one bit so addresses can be range-checked even when
    // DEPTH is an exact power of two.
    localparam logic [AW:0]   c_DEPTH   = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] c_LAST    = AW'(DEPTH - 1);
    localparam bit            c_ZERO_EN = (ZERO_REG != 0);
    localparam bit            c_BYP_EN  = (BYPASS != 0);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [AW-1:0]    r_ptr;
    logic [AW-1:0]    w_ptr_next;
    logic             r_clr_done;
    logic             w_clr_done_next;
    logic             r_wr_err;
    logic             w_wr_err_next;
    logic [WIDTH-1:0] r_regs [DEPTH];

    logic w_idle;
    logic w_wa_ignored;
    logic w_wr_commit;
    logic w_byp1;
    logic w_byp2;
    logic w_ra1_masked;
    logic w_ra2_masked;

    // A write only lands (and only forwards) when the bank is idle and the
    // address names a real, writable register.
    assign w_idle       = (r_state == ST_IDLE);
    assign w_wa_ignored = ({1'b0, wa3} >= c_DEPTH) || (c_ZERO_EN && (wa3 == '0));
    assign w_wr_commit  = w_idle && we3 && !w_wa_ignored;

    assign w_byp1       = c_BYP_EN && w_wr_commit && (wa3 == ra1);
    assign w_byp2       = c_BYP_EN && w_wr_commit && (wa3 == ra2);
    assign w_ra1_masked = ({1'b0, ra1} >= c_DEPTH) || (c_ZERO_EN && (ra1 == '0));
    assign w_ra2_masked = ({1'b0, ra2} >= c_DEPTH) || (c_ZERO_EN && (ra2 == '0));

    assign rd1 = w_byp1 ? wd3 : (w_ra1_masked ? '0 : r_regs[ra1]);
    assign rd2 = w_byp2 ? wd3 : (w_ra2_masked ? '0 : r_regs[ra2]);

    assign clr_busy = (r_state == ST_CLEAR);
    assign clr_done = r_clr_done;
    assign wr_err   = r_wr_err;

    // Register array: clear engine has priority, otherwise accept the write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (r_state == ST_CLEAR) begin
            r_regs[r_ptr] <= '0;
        end else if (w_wr_commit) begin
            r_regs[wa3] <= wd3;
        end
    end

    // Clear FSM state, pointer and registered status pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_clr_done <= 1'b0;
            r_wr_err   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_ptr      <= w_ptr_next;
            r_clr_done <= w_clr_done_next;
            r_wr_err   <= w_wr_err_next;
        end
    end

    // Next-state logic: walk the pointer once over the array, ignore
    // clr_start while clearing, and flag any write that arrives meanwhile.
    always_comb begin
        w_state_next    = r_state;
        w_ptr_next      = r_ptr;
        w_clr_done_next = 1'b0;
        w_wr_err_next   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (clr_start) begin
                    w_state_next = ST_CLEAR;
                    w_ptr_next   = '0;
                end
            end
            ST_CLEAR: begin
                w_wr_err_next = we3;
                if (r_ptr == c_LAST) begin
                    w_state_next    = ST_IDLE;
                    w_ptr_next      = '0;
                    w_clr_done_next = 1'b1;
                end else begin
                    w_ptr_next = r_ptr + 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_ptr_next   = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/register_bank_param.md
# register_bank_param

Parametrised two-read/one-write register bank: the successor to the fixed 8×8 bank in the datapath practice series. Width, depth and hardwired-zero behaviour are set by parameters. It adds same-cycle write-to-read bypass and a sequential bulk-clear engine with a busy/done handshake. It sits between the decode stage (read addresses) and writeback (write port) of the practice CPU datapath.

## Interface
- WIDTH, 8: data width in bits (≥1).
- DEPTH, 8: number of registers (≥2; need not be a power of two).
- ZERO_REG, 1: 1 makes register 0 read as zero and ignore writes; 0 makes it an ordinary register.
- BYPASS, 1: 1 enables write-to-read forwarding; 0 disables it.
- AW (local): $clog2(DEPTH).
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- we3  input  1  write enable.
- wa3  input  AW  write address.
- wd3  input  WIDTH  write data.
- ra1  input  AW  read address, port 1.
- ra2  input  AW  read address, port 2.
- rd1  output  WIDTH  read data, port 1 (combinational).
- rd2  output  WIDTH  read data, port 2 (combinational).
- clr_start  input  1  bulk-clear request, single-cycle pulse.
- clr_busy  output  1  bulk clear in progress.
- clr_done  output  1  one-cycle pulse when the clear completes.
- wr_err  output  1  one-cycle pulse: a write was dropped during a clear.

## Operation
- Reset (rst=0) takes effect immediately, with no clock edge needed:
  - all registers go to 0;
  - the FSM goes to IDLE and the clear pointer to 0;
  - clr_busy, clr_done and wr_err go to 0.
- Write: when we3=1 and the FSM is IDLE, reg[wa3] <= wd3 at the rising edge.
- A write is ignored silently, with no wr_err, when either:
  - ZERO_REG=1 and wa3=0; or
  - wa3 ≥ DEPTH.
- Read: rdN = reg[raN], except:
  - rdN = 0 when raN ≥ DEPTH;
  - rdN = 0 when ZERO_REG=1 and raN=0.
- Bypass applies when all of the following hold: BYPASS=1, FSM IDLE, we3=1, wa3=raN, and the write is not ignored. Then rdN = wd3 in the same cycle. Both ports may bypass simultaneously.
- FSM states: IDLE and CLEAR.
  - IDLE→CLEAR on clr_start=1 at an edge. The pointer loads 0.
  - In CLEAR, each edge sets reg[ptr] <= 0 and ptr <= ptr+1.
  - CLEAR→IDLE on the edge that clears ptr=DEPTH-1. The pointer returns to 0.
  - clr_start is ignored while in CLEAR; it neither restarts nor extends the clear.
- clr_busy = (state==CLEAR).
- clr_done is registered. It is high for exactly the one cycle after CLEAR→IDLE.
- Writes during CLEAR:
  - we3=1 at an edge while in CLEAR drops the write; no register changes from wd3.
  - wr_err is high the following cycle. This includes the final CLEAR edge.
  - Bypass is disabled throughout CLEAR.
- Reads during CLEAR return current contents: registers below ptr read 0, the rest keep their old values.
- Reset asserted mid-clear aborts the clear: clr_done does not pulse, and all registers are 0 anyway.

## Timing
- Read latency: 0 cycles (combinational from raN and register state).
- Write-to-read:
  - BYPASS=1: same cycle;
  - BYPASS=0: visible from the cycle after the write edge.
- Clear duration: clr_start sampled at edge T0 gives clr_busy high from T0 until edge T0+DEPTH. clr_done is high from T0+DEPTH until T0+DEPTH+1.
- A clr_start coincident with we3=1 in IDLE: the write commits at that edge; the clear erases it later.
- Minimum interval from clr_done to an accepted clr_start: 0 cycles. A clr_start in the clr_done cycle starts a new clear.
- All outputs are glitch-tolerant only at the sampling edge. The bench checks rdN at least 1 ns after input changes.

## Test plan
- Reset then write: WIDTH=8, DEPTH=8.
  - Release rst; write 0xAA to reg1, then 0xBB to reg2. With ra1=1, ra2=2 → rd1=0xAA, rd2=0xBB.
  - Write 0xFF to reg0 → ra1=0 reads 0x00.
- Bypass:
  - BYPASS=1: we3=1, wa3=3, wd3=0xCC, ra1=ra2=3 → rd1=rd2=0xCC before the edge.
  - BYPASS=0: same stimulus → rd1=rd2=0x00 until after the edge.
- Bulk clear: fill regs 1–7 with 0x11..0x77, pulse clr_start.
  - clr_busy is high for exactly 8 cycles, then clr_done is high for 1 cycle.
  - At busy cycle 4, ra1=2 → 0x00 and ra2=5 → 0x55.
  - After done, all reads → 0x00.
- Write during clear: we3=1, wa3=6, wd3=0x66 in busy cycle 3 → wr_err pulses in cycle 4; reg6 reads 0x00 after done. A clr_start in busy cycle 5 does not change the done timing.
- Reset mid-clear: assert rst in busy cycle 2 → clr_busy=0 immediately, no clr_done pulse, all registers read 0x00.
- Parametrised instance: WIDTH=16, DEPTH=5, ZERO_REG=0.
  - Write 0xBEEF to reg0 → reads 0xBEEF.
  - ra1=6 → 0x0000.
  - A write to wa3=7 is ignored, with no wr_err.
  - A clear takes 5 cycles.
